// File: rtl/lab8_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse position tracker.
package lab8_mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } mouse_state_t;

    // Status byte bit positions
    localparam int unsigned SYNC = 3;
    localparam int unsigned XS   = 4;
    localparam int unsigned YS   = 5;
    localparam int unsigned XO   = 6;
    localparam int unsigned YO   = 7;

    localparam int unsigned ARITH_W = 12;

    // Only the status fields that affect the outputs are kept.
    typedef struct packed {
        logic yo;
        logic xo;
        logic ys;
        logic xs;
        logic btn_r;
        logic btn_l;
    } mouse_status_t;

endpackage

// File: rtl/mouse_axis_clamp.sv
// One cursor axis: position plus (or minus) a 9-bit signed delta, clamped to [0, MAX].
module mouse_axis_clamp
    import lab8_mouse_pkg::*;
#(
    parameter int MAX    = 639,
    parameter bit NEGATE = 1'b0
) (
    input  logic              [9:0] i_pos,
    input  logic signed       [8:0] i_delta,
    output logic              [9:0] o_pos
);

    localparam logic signed [ARITH_W-1:0] MAX_S = ARITH_W'(MAX);

    logic signed [ARITH_W-1:0] w_pos;
    logic signed [ARITH_W-1:0] w_delta;
    logic signed [ARITH_W-1:0] w_sum;

    // Negation happens at full width so a delta of -256 becomes +256 without wrapping.
    always_comb begin
        w_pos   = $signed({{(ARITH_W-10){1'b0}}, i_pos});
        w_delta = $signed({{(ARITH_W-9){i_delta[8]}}, i_delta});
        w_sum   = NEGATE ? (w_pos - w_delta) : (w_pos + w_delta);
        if (w_sum < 0) begin
            o_pos = '0;
        end else if (w_sum > MAX_S) begin
            o_pos = 10'(MAX);
        end else begin
            o_pos = w_sum[9:0];
        end
    end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 mouse packets and tracks a clamped cursor position and button state.
module mouse_pos_tracker
    import lab8_mouse_pkg::*;
#(
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int X_INIT  = 320,
    parameter int Y_INIT  = 240,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       btn_left,
    output logic       btn_right,
    output logic       pkt_valid,
    output logic       sync_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mouse_state_t  r_state;
    mouse_status_t r_status;
    logic [7:0]    r_dx;
    logic [7:0]    r_dy;
    logic [CNT_W-1:0] r_idle;
    logic          r_apply;
    logic          r_err_pend;
    logic [9:0]    r_pos_x;
    logic [9:0]    r_pos_y;
    logic          r_btn_l;
    logic          r_btn_r;
    logic          r_pkt_valid;
    logic          r_sync_err;

    logic          w_timeout;
    logic          w_as_b0;
    logic          w_err;
    logic [9:0]    w_new_x;
    logic [9:0]    w_new_y;

    assign w_timeout = (r_state != WAIT_B0) && (r_idle == CNT_W'(TIMEOUT));
    assign w_as_b0   = (r_state == WAIT_B0) || w_timeout;
    assign w_err     = w_timeout || (rx_valid && w_as_b0 && !rx_byte[SYNC]);

    mouse_axis_clamp #(.MAX(X_MAX), .NEGATE(1'b0)) u_clamp_x (
        .i_pos   (r_pos_x),
        .i_delta ($signed({r_status.xs, r_dx})),
        .o_pos   (w_new_x)
    );

    mouse_axis_clamp #(.MAX(Y_MAX), .NEGATE(1'b1)) u_clamp_y (
        .i_pos   (r_pos_y),
        .i_delta ($signed({r_status.ys, r_dy})),
        .o_pos   (w_new_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= WAIT_B0;
            r_status    <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_idle      <= '0;
            r_apply     <= 1'b0;
            r_err_pend  <= 1'b0;
            r_pos_x     <= 10'(X_INIT);
            r_pos_y     <= 10'(Y_INIT);
            r_btn_l     <= 1'b0;
            r_btn_r     <= 1'b0;
            r_pkt_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_apply     <= 1'b0;
            r_pkt_valid <= r_apply;

            if (r_apply) begin
                if (!r_status.xo) r_pos_x <= w_new_x;
                if (!r_status.yo) r_pos_y <= w_new_y;
                r_btn_l <= r_status.btn_l;
                r_btn_r <= r_status.btn_r;
            end

            // An error that lands on the apply cycle is held back one cycle so the pulses never overlap.
            if (r_apply) begin
                r_sync_err <= 1'b0;
                r_err_pend <= r_err_pend | w_err;
            end else begin
                r_sync_err <= w_err | r_err_pend;
                r_err_pend <= 1'b0;
            end

            if (rx_valid || w_timeout) begin
                r_idle <= '0;
            end else if (r_state != WAIT_B0) begin
                r_idle <= r_idle + CNT_W'(1);
            end

            if (w_as_b0) begin
                if (rx_valid && rx_byte[SYNC]) begin
                    r_status <= '{yo: rx_byte[YO], xo: rx_byte[XO], ys: rx_byte[YS],
                                  xs: rx_byte[XS], btn_r: rx_byte[1], btn_l: rx_byte[0]};
                    r_state  <= WAIT_B1;
                end else begin
                    r_state  <= WAIT_B0;
                end
            end else if (rx_valid) begin
                if (r_state == WAIT_B1) begin
                    r_dx    <= rx_byte;
                    r_state <= WAIT_B2;
                end else begin
                    r_dy    <= rx_byte;
                    r_apply <= 1'b1;
                    r_state <= WAIT_B0;
                end
            end
        end
    end

    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign btn_left  = r_btn_l;
    assign btn_right = r_btn_r;
    assign pkt_valid = r_pkt_valid;
    assign sync_err  = r_sync_err;

endmodule

// File: doc/mouse_pos_tracker.md
MOUSE_POS_TRACKER -- requirements
Module: mouse_pos_tracker

Interface
REQ-001 Parameter: X_MAX, 639, largest legal pos_x.
REQ-002 Parameter: Y_MAX, 479, largest legal pos_y.
REQ-003 Parameter: X_INIT, 320, pos_x after reset.
REQ-004 Parameter: Y_INIT, 240, pos_y after reset.
REQ-005 Parameter: TIMEOUT, 50000, maximum idle clk cycles between bytes of one packet.
REQ-006 Port: clk  input  1  clock; all state changes on rising edge.
REQ-007 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-008 Port: rx_byte  input  8  byte from the PS/2 receiver.
REQ-009 Port: rx_valid  input  1  one-cycle strobe; rx_byte valid this cycle.
REQ-010 Port: pos_x  output  10  cursor X; feeds the POS_X PIO in_port.
REQ-011 Port: pos_y  output  10  cursor Y; feeds the POS_Y PIO in_port.
REQ-012 Port: btn_left  output  1  left button state from the last accepted packet.
REQ-013 Port: btn_right  output  1  right button state from the last accepted packet.
REQ-014 Port: pkt_valid  output  1  one-cycle pulse when a packet is applied.
REQ-015 Port: sync_err  output  1  one-cycle pulse when a byte or partial packet is discarded.

Function
REQ-016 FSM states: WAIT_B0, WAIT_B1, WAIT_B2; a state advances only on a cycle with rx_valid=1.
REQ-017 WAIT_B0: rx_valid with rx_byte[3]=1 -> latch status byte, go to WAIT_B1.
REQ-018 WAIT_B0: rx_valid with rx_byte[3]=0 -> drop the byte, pulse sync_err, stay in WAIT_B0.
REQ-019 WAIT_B1: rx_valid -> latch dx byte, go to WAIT_B2.
REQ-020 WAIT_B2: rx_valid -> latch dy byte, apply the packet, return to WAIT_B0.
REQ-021 dx = signed 9-bit {status[4], dx byte}; dy = signed 9-bit {status[5], dy byte}.
REQ-022 New X = pos_x + dx; new Y = pos_y - dy (screen Y grows downward).
REQ-023 Sums computed at 12-bit signed width; results clamped to [0, X_MAX] and [0, Y_MAX].
REQ-024 Outputs update, and pkt_valid pulses, on the clk edge after the edge that accepts byte 2 (latency 1).
REQ-025 Overflow: status[6]=1 suppresses the X update; status[7]=1 suppresses the Y update; buttons still update and pkt_valid still pulses.
REQ-026 btn_left = status[0]; btn_right = status[1].
REQ-027 Idle counter clears on every rx_valid and counts only in WAIT_B1 and WAIT_B2.
REQ-028 Idle counter reaching TIMEOUT -> return to WAIT_B0, pulse sync_err, discard latched bytes; outputs unchanged.
REQ-029 rx_valid on the same cycle as a timeout -> the timeout wins and the byte is evaluated as a byte 0.
REQ-030 pkt_valid and sync_err never assert in the same cycle.

Reset
REQ-031 While reset_n=0: state=WAIT_B0, pos_x=X_INIT, pos_y=Y_INIT, buttons=0, pkt_valid=0, sync_err=0, idle counter=0.
REQ-032 Reset mid-packet discards all partial bytes; the first post-reset byte is treated as byte 0.

Structure
REQ-033 Package lab8_mouse_pkg holds the FSM state enum, the status-bit index constants (SYNC=3, XS=4, YS=5, XO=6, YO=7) and the 12-bit arithmetic width constant.
REQ-034 One sub-module, mouse_axis_clamp (10-bit position, 9-bit signed delta, max parameter -> clamped 10-bit result), instantiated once per axis, Y with the delta negated.

Verification
REQ-035 Reset, then bytes 0x08,0x0A,0x05 -> pos_x=330, pos_y=235, btns 0/0, one pkt_valid pulse.
REQ-036 From 320,240: bytes 0x39,0x00,0x00 -> dx=-256, dy=-256 -> pos_x=64, pos_y=479 (clamped Y).
REQ-037 From pos_x=630: bytes 0x09,0x20,0x00 -> pos_x=639, btn_left=1.
REQ-038 Byte 0x00 in WAIT_B0 -> sync_err pulse, no state change; then 0x08,0x01,0x01 -> applied normally.
REQ-039 Bytes 0x08,0x05, then no rx_valid for 50000 cycles -> sync_err pulse; next 0x08,0x01,0x00 -> pos_x+1.
REQ-040 Bytes 0x48,0x7F,0x03 -> X unchanged, pos_y-3, pkt_valid pulse; reset_n low after byte 1 of a later packet -> X_INIT/Y_INIT restored, FSM in WAIT_B0.
